// File: rtl/ex_unit_pkg.sv
// ============================================================================
// Module      : ex_unit_pkg
// Description : Shared opcode encodings, register-address constants and the
//               divider state type for the execute stage and its divider.
//               Optional feature macro consumed by users of this package:
//               SIRIUS_EX_DIV_EN (builds the iterative divider).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_unit_pkg;

    // AluSelBus: result class selected by decode
    localparam logic [2:0] c_EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] c_EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] c_EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] c_EXE_RES_DIV   = 3'b110;

    // AluOpBus: operation subtype from decode
    localparam logic [7:0] c_EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] c_EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] c_EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] c_EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] c_EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] c_EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] c_EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] c_EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] c_EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] c_EXE_DIVU_OP = 8'b0001_1011;

    // SPECIAL-class funct codes of the divide instructions
    localparam logic [5:0] c_EXE_DIV  = 6'b011010;
    localparam logic [5:0] c_EXE_DIVU = 6'b011011;

    // Destination address used when no GPR is written
    localparam logic [4:0] c_NOP_REG_ADDR = 5'b00000;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,   // DivFree
        DIV_ON   = 2'b01,   // DivOn
        DIV_END  = 2'b10,   // DivEnd
        DIV_ZERO = 2'b11    // DivByZero
    } div_state_e;

    localparam logic c_DIV_RESULT_READY     = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY = 1'b0;

endpackage : ex_unit_pkg

`default_nettype wire

// File: rtl/ex_unit_div.sv
// ============================================================================
// Module      : div_radix2
// Description : Iterative radix-2 restoring divider, one quotient bit per
//               cycle. Signed mode divides operand magnitudes, then negates
//               the quotient when operand signs differ and gives the
//               remainder the sign of the dividend. Divide-by-zero returns
//               zero quotient and remainder after a short fixed sequence.
// Ports       : clk, rst (async, active-low)
//               signed_i  - 1: DIV, 0: DIVU
//               start_i   - request a divide (taken only from DIV_IDLE)
//               annul_i   - abandon any divide in progress
//               opdata1_i - dividend, opdata2_i - divisor
//               result_o  - {remainder, quotient}, valid while ready_o
//               ready_o   - high for the single DIV_END cycle
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_radix2
    import ex_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DIV_ITER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int                c_CNT_W    = $clog2(DIV_ITER);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_ITER - 1);

    div_state_e           r_state;
    div_state_e           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_rem;      // partial remainder
    logic [DATA_W-1:0]    r_quo;      // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]    r_dsr;      // divisor magnitude
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic                 w_accept;
    logic                 w_dvd_neg;
    logic                 w_dsr_neg;
    logic [DATA_W:0]      w_trial;    // 33-bit partial remainder for this step
    logic [DATA_W:0]      w_diff;
    logic                 w_ge;
    logic [DATA_W-1:0]    w_quo_out;
    logic [DATA_W-1:0]    w_rem_out;

    assign w_accept  = start_i & ~annul_i;
    assign w_dvd_neg = signed_i & opdata1_i[DATA_W-1];
    assign w_dsr_neg = signed_i & opdata2_i[DATA_W-1];

    // Restoring step: bring down the next dividend bit and try to subtract.
    // The remainder is always below the divisor, so the trial never exceeds
    // 2*divisor and a clear top bit of the difference means "fits".
    assign w_trial = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_trial - {1'b0, r_dsr};
    assign w_ge    = ~w_diff[DATA_W];

    // -------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ON: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = DIV_END;
                end
            end
            DIV_ZERO: w_state_nxt = DIV_END;
            DIV_END:  w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (annul_i) begin
            w_state_nxt = DIV_IDLE;
        end
    end

    // --------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dsr   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (annul_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_dvd_neg ? (-opdata1_i) : opdata1_i;
                        r_dsr   <= w_dsr_neg ? (-opdata2_i) : opdata2_i;
                        r_neg_q <= w_dvd_neg ^ w_dsr_neg;
                        r_neg_r <= w_dvd_neg;
                    end
                end
                DIV_ON: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], w_ge};
                end
                DIV_ZERO: begin
                    r_rem   <= '0;
                    r_quo   <= '0;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Sign fix-up; only sampled by the consumer while ready_o is high
    assign w_quo_out = r_neg_q ? (-r_quo) : r_quo;
    assign w_rem_out = r_neg_r ? (-r_rem) : r_rem;

    assign result_o = {w_rem_out, w_quo_out};
    assign ready_o  = (r_state == DIV_END) ? c_DIV_RESULT_READY : c_DIV_RESULT_NOT_READY;

endmodule : div_radix2

`default_nettype wire

// File: rtl/ex_unit.sv
// ============================================================================
// Module      : ex_unit
// Description : Execute stage. Single-cycle logic and shift operations,
//               registered writeback triple for mem stage and EX forwarding,
//               and (when SIRIUS_EX_DIV_EN is defined) DIV/DIVU through an
//               iterative radix-2 divider with a stall request to ctrl.
//               With SIRIUS_EX_DIV_EN undefined, divides behave as NOP and
//               hi_o/lo_o/whilo_o/stallreq_o are constant zero.
// Ports       : clk, rst (async, active-low)
//               valid_i, flush_i, aluop_i[7:0], alusel_i[2:0]
//               reg1_i, reg2_i       - operands
//               wd_i[4:0], wreg_i    - destination and write enable
//               wdata_o, wd_o, wreg_o - registered GPR writeback
//               hi_o, lo_o, whilo_o  - registered HI/LO writeback
//               stallreq_o           - combinational stall request
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_unit
    import ex_unit_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef SIRIUS_EX_DIV_EN
    ,
    parameter int DIV_ITER = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o,
    output logic              stallreq_o
);

    localparam int c_SHAMT_W = $clog2(DATA_W);

    logic [c_SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]    w_logic_res;
    logic [DATA_W-1:0]    w_shift_res;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_wreg;

    logic [DATA_W-1:0]    r_wdata;
    logic [4:0]           r_wd;
    logic                 r_wreg;

    assign w_shamt = reg1_i[c_SHAMT_W-1:0];

    always_comb begin
        w_logic_res = '0;
        case (aluop_i)
            c_EXE_OR_OP:  w_logic_res = reg1_i | reg2_i;
            c_EXE_AND_OP: w_logic_res = reg1_i & reg2_i;
            c_EXE_XOR_OP: w_logic_res = reg1_i ^ reg2_i;
            c_EXE_NOR_OP: w_logic_res = ~(reg1_i | reg2_i);
            default:      w_logic_res = '0;
        endcase
    end

    always_comb begin
        w_shift_res = '0;
        case (aluop_i)
            c_EXE_SLL_OP: w_shift_res = reg2_i << w_shamt;
            c_EXE_SRL_OP: w_shift_res = reg2_i >> w_shamt;
            c_EXE_SRA_OP: w_shift_res = $signed(reg2_i) >>> w_shamt;
            default:      w_shift_res = '0;
        endcase
    end

    // Divides, NOPs and unknown classes all land in the default arm and
    // write no GPR.
    always_comb begin
        w_wdata = '0;
        w_wreg  = 1'b0;
        case (alusel_i)
            c_EXE_RES_LOGIC: begin
                w_wdata = w_logic_res;
                w_wreg  = wreg_i;
            end
            c_EXE_RES_SHIFT: begin
                w_wdata = w_shift_res;
                w_wreg  = wreg_i;
            end
            default: begin
                w_wdata = '0;
                w_wreg  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdata <= '0;
            r_wd    <= c_NOP_REG_ADDR;
            r_wreg  <= 1'b0;
        end else if (flush_i || !valid_i) begin
            r_wdata <= '0;
            r_wd    <= c_NOP_REG_ADDR;
            r_wreg  <= 1'b0;
        end else begin
            r_wdata <= w_wdata;
            r_wd    <= wd_i;
            r_wreg  <= w_wreg;
        end
    end

    assign wdata_o = r_wdata;
    assign wd_o    = r_wd;
    assign wreg_o  = r_wreg;

`ifdef SIRIUS_EX_DIV_EN
    logic                 w_is_div;
    logic                 w_div_signed;
    logic                 w_div_ready;
    logic [2*DATA_W-1:0]  w_div_result;
    logic [DATA_W-1:0]    r_hi;
    logic [DATA_W-1:0]    r_lo;
    logic                 r_whilo;

    assign w_div_signed = (aluop_i == c_EXE_DIV_OP);
    assign w_is_div     = (alusel_i == c_EXE_RES_DIV) &&
                          ((aluop_i == c_EXE_DIV_OP) || (aluop_i == c_EXE_DIVU_OP));

    div_radix2 #(
        .DATA_W   (DATA_W),
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (w_div_signed),
        .start_i   (valid_i & w_is_div),
        .annul_i   (flush_i),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .result_o  (w_div_result),
        .ready_o   (w_div_ready)
    );

    // Stall releases in DIV_END so the pipeline advances on the same edge
    // that captures HI/LO.
    assign stallreq_o = valid_i & w_is_div & ~w_div_ready;

    // flush_i wins over a result that is ready on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
        end else if (flush_i) begin
            r_whilo <= 1'b0;
        end else if (w_div_ready) begin
            r_hi    <= w_div_result[2*DATA_W-1:DATA_W];
            r_lo    <= w_div_result[DATA_W-1:0];
            r_whilo <= 1'b1;
        end else begin
            r_whilo <= 1'b0;
        end
    end

    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign whilo_o = r_whilo;
`else
    assign stallreq_o = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
    assign whilo_o    = 1'b0;
`endif

endmodule : ex_unit

`default_nettype wire

// File: tb/tb_ex_unit.sv
// ============================================================================
// Module      : tb_ex_unit
// Description : Self-checking bench for ex_unit: vector table for logic and
//               shift ops, random ALU traffic against a reference model,
//               directed and random divides, flush and mid-divide reset.
//               Adapts its expectations to SIRIUS_EX_DIV_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_unit;
    import ex_unit_pkg::*;

`ifdef SIRIUS_EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    ex_unit dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .flush_i    (flush_i),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_o    (wdata_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .whilo_o    (whilo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic        flush;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] e_wdata;
        logic [4:0]  e_wd;
        logic        e_wreg;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [7:0] op,
                         input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic w);
        valid_i = v; flush_i = f; aluop_i = op; alusel_i = sel;
        reg1_i = a; reg2_i = b; wd_i = d; wreg_i = w;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, c_EXE_NOP_OP, c_EXE_RES_NOP, '0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference ALU computed from the operation definitions
    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        s = int'(a[4:0]);
        case (op)
            c_EXE_OR_OP:  return a | b;
            c_EXE_AND_OP: return a & b;
            c_EXE_XOR_OP: return a ^ b;
            c_EXE_NOR_OP: return ~(a | b);
            c_EXE_SLL_OP: return b << s;
            c_EXE_SRL_OP: return b >> s;
            c_EXE_SRA_OP: return (b >> s) | ({32{b[31]}} & ~(32'hFFFF_FFFF >> s));
            default:      return 32'h0;
        endcase
    endfunction

    // Reference divide via 64-bit integer arithmetic (truncating division)
    function automatic void div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, qq, rr;
        if (b == 32'h0) begin
            q = '0; r = '0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present a divide and behave like the upstream pipeline: hold while
    // stalled, advance once the stall drops.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input string nm);
        logic [31:0] q, r;
        int edges, nst, exp_edges, exp_nst;
        bit got, st, bad_wreg;
        div_model(sgn, a, b, q, r);
        drive(1'b1, 1'b0, sgn ? c_EXE_DIV_OP : c_EXE_DIVU_OP, c_EXE_RES_DIV, a, b, 5'd9, 1'b1);
        edges = 0; nst = 0; got = 1'b0; bad_wreg = 1'b0;
        while (!got && edges < 40) begin
            #1;
            st = stallreq_o;
            if (st) nst++;
            tick();
            edges++;
            if (wreg_o) bad_wreg = 1'b1;
            if (whilo_o) got = 1'b1;
            if (!st) drive_idle();
        end
        drive_idle();
        exp_edges = DIV_EN ? ((b == 0) ? 3 : 34) : 40;
        exp_nst   = DIV_EN ? ((b == 0) ? 2 : 33) : 0;
        if (DIV_EN) begin
            cur_hi = r;
            cur_lo = q;
        end
        chk({nm, " whilo"}, 64'(got), 64'(DIV_EN));
        chk({nm, " latency"}, 64'(edges), 64'(exp_edges));
        chk({nm, " stall_cycles"}, 64'(nst), 64'(exp_nst));
        chk({nm, " lo"}, 64'(lo_o), 64'(cur_lo));
        chk({nm, " hi"}, 64'(hi_o), 64'(cur_hi));
        chk({nm, " wreg"}, 64'(bad_wreg), 64'h0);
        tick();
        chk({nm, " whilo_pulse"}, 64'(whilo_o), 64'h0);
    endtask

    initial begin
        logic [7:0] ops[7];
        int pulses;

        ops[0] = c_EXE_OR_OP;  ops[1] = c_EXE_AND_OP; ops[2] = c_EXE_XOR_OP;
        ops[3] = c_EXE_NOR_OP; ops[4] = c_EXE_SLL_OP; ops[5] = c_EXE_SRL_OP;
        ops[6] = c_EXE_SRA_OP;

        //            valid flush op            sel              reg1          reg2          wd    wreg exp_wdata     e_wd  e_wreg
        tbl[0]  = '{1'b1, 1'b0, c_EXE_OR_OP,  c_EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd5,  1'b1, 32'h0000FFFF, 5'd5,  1'b1};
        tbl[1]  = '{1'b1, 1'b0, c_EXE_SRA_OP, c_EXE_RES_SHIFT, 32'd4,        32'h80000010, 5'd6,  1'b1, 32'hF8000001, 5'd6,  1'b1};
        tbl[2]  = '{1'b1, 1'b0, c_EXE_SRL_OP, c_EXE_RES_SHIFT, 32'd4,        32'h80000010, 5'd7,  1'b1, 32'h08000001, 5'd7,  1'b1};
        tbl[3]  = '{1'b1, 1'b0, c_EXE_AND_OP, c_EXE_RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd8,  1'b1, 32'h0F000F00, 5'd8,  1'b1};
        tbl[4]  = '{1'b1, 1'b0, c_EXE_XOR_OP, c_EXE_RES_LOGIC, 32'hAAAA5555, 32'hFFFF0000, 5'd9,  1'b1, 32'h55555555, 5'd9,  1'b1};
        tbl[5]  = '{1'b1, 1'b0, c_EXE_NOR_OP, c_EXE_RES_LOGIC, 32'h0000FFFF, 32'h00FF0000, 5'd10, 1'b1, 32'hFF000000, 5'd10, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, c_EXE_SLL_OP, c_EXE_RES_SHIFT, 32'd31,       32'h00000001, 5'd11, 1'b1, 32'h80000000, 5'd11, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, c_EXE_SLL_OP, c_EXE_RES_SHIFT, 32'h00000020, 32'h00001234, 5'd12, 1'b1, 32'h00001234, 5'd12, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, c_EXE_SRA_OP, c_EXE_RES_SHIFT, 32'd31,       32'h7FFFFFFF, 5'd13, 1'b1, 32'h00000000, 5'd13, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, c_EXE_OR_OP,  c_EXE_RES_NOP,   32'h12345678, 32'h1,        5'd14, 1'b1, 32'h00000000, 5'd14, 1'b0};
        tbl[10] = '{1'b1, 1'b0, c_EXE_OR_OP,  3'b101,          32'h12345678, 32'h1,        5'd15, 1'b1, 32'h00000000, 5'd15, 1'b0};
        tbl[11] = '{1'b0, 1'b0, c_EXE_OR_OP,  c_EXE_RES_LOGIC, 32'h12345678, 32'h1,        5'd16, 1'b1, 32'h00000000, 5'd0,  1'b0};
        tbl[12] = '{1'b1, 1'b1, c_EXE_OR_OP,  c_EXE_RES_LOGIC, 32'h12345678, 32'h1,        5'd17, 1'b1, 32'h00000000, 5'd0,  1'b0};
        tbl[13] = '{1'b1, 1'b0, c_EXE_OR_OP,  c_EXE_RES_LOGIC, 32'h00000F00, 32'h000000F0, 5'd18, 1'b0, 32'h00000FF0, 5'd18, 1'b0};

        // ---------------------------------------------------- reset state
        drive(1'b1, 1'b0, c_EXE_OR_OP, c_EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b1);
        tick();
        tick();
        chk("reset wdata", 64'(wdata_o), 64'h0);
        chk("reset wd", 64'(wd_o), 64'(c_NOP_REG_ADDR));
        chk("reset wreg", 64'(wreg_o), 64'h0);
        chk("reset hi_lo", {hi_o, lo_o}, 64'h0);
        chk("reset whilo", 64'(whilo_o), 64'h0);
        chk("reset stall", 64'(stallreq_o), 64'h0);
        drive_idle();
        rst = 1'b1;
        tick();

        // -------------------------------------------------- vector table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].valid, tbl[i].flush, tbl[i].aluop, tbl[i].alusel,
                  tbl[i].r1, tbl[i].r2, tbl[i].wd, tbl[i].wreg);
            tick();
            chk($sformatf("vec%0d wdata", i), 64'(wdata_o), 64'(tbl[i].e_wdata));
            chk($sformatf("vec%0d wd", i), 64'(wd_o), 64'(tbl[i].e_wd));
            chk($sformatf("vec%0d wreg", i), 64'(wreg_o), 64'(tbl[i].e_wreg));
        end

        // --------------------------------------------- random ALU traffic
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  op;
            logic [31:0] a, b;
            logic [4:0]  d;
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            d  = 5'($urandom_range(1, 31));
            drive(1'b1, 1'b0, op,
                  (op == c_EXE_SLL_OP || op == c_EXE_SRL_OP || op == c_EXE_SRA_OP) ?
                      c_EXE_RES_SHIFT : c_EXE_RES_LOGIC,
                  a, b, d, 1'b1);
            tick();
            chk($sformatf("rand%0d op%h wdata", i, op), 64'(wdata_o), 64'(alu_model(op, a, b)));
            chk($sformatf("rand%0d wd", i), 64'(wd_o), 64'(d));
        end
        drive_idle();
        tick();

        // ------------------------------------------------ directed divides
        run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(1'b1, 32'd5, 32'd0, "div_5_0");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

        // -------------------------------------------------- random divides
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 100));
                1:       b = 32'h0;
                default: b = $urandom;
            endcase
            run_div(1'($urandom_range(0, 1)), a, b, $sformatf("rdiv%0d", i));
        end

        // ---------------------------------------- flush at iteration 10
        drive(1'b1, 1'b0, c_EXE_DIVU_OP, c_EXE_RES_DIV, 32'd1000, 32'd7, 5'd4, 1'b1);
        for (int i = 0; i < 11; i++) tick();
        flush_i = 1'b1;
        tick();
        chk("flush10 whilo", 64'(whilo_o), 64'h0);
        chk("flush10 wreg", 64'(wreg_o), 64'h0);
        drive_idle();
        #1;
        chk("flush10 stall", 64'(stallreq_o), 64'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (whilo_o) pulses++;
        end
        chk("flush10 no_whilo", 64'(pulses), 64'h0);
        chk("flush10 hi_lo_kept", {hi_o, lo_o}, {cur_hi, cur_lo});
        run_div(1'b0, 32'd100, 32'd7, "after_flush");

        // -------------------------------- flush coinciding with DIV_END
        drive(1'b1, 1'b0, c_EXE_DIVU_OP, c_EXE_RES_DIV, 32'd555, 32'd11, 5'd4, 1'b1);
        begin
            int cyc;
            bit done;
            cyc = 0; done = 1'b0;
            while (!done && cyc < 40) begin
                #1;
                if (!stallreq_o) begin
                    flush_i = 1'b1;
                    done = 1'b1;
                end
                tick();
                cyc++;
            end
            chk("flush_end reached", 64'(done), 64'h1);
        end
        chk("flush_end whilo", 64'(whilo_o), 64'h0);
        chk("flush_end hi_lo_kept", {hi_o, lo_o}, {cur_hi, cur_lo});
        drive_idle();
        tick();
        chk("flush_end whilo_late", 64'(whilo_o), 64'h0);

        // ------------------------------------- async reset mid-divide
        drive(1'b1, 1'b0, c_EXE_DIVU_OP, c_EXE_RES_DIV, 32'd1000, 32'd3, 5'd4, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        #2;
        drive_idle();
        rst = 1'b0;
        #1;
        cur_hi = '0;
        cur_lo = '0;
        chk("midrst hi_lo", {hi_o, lo_o}, 64'h0);
        chk("midrst wdata_wd_wreg", {27'h0, wdata_o, wd_o, wreg_o}, 64'h0);
        chk("midrst whilo_stall", {62'h0, whilo_o, stallreq_o}, 64'h0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (whilo_o) pulses++;
        end
        chk("midrst no_whilo", 64'(pulses), 64'h0);
        run_div(1'b0, 32'd9, 32'd3, "divu_9_3");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ex_unit

`default_nettype wire
